bus_arb2m: RTL
==============

Name: bus_arb2m

Overview:
Shared-bus interconnect for two bus masters and two memory-mapped slaves. It is the successor to the single-master bus. It adds round-robin arbitration between the masters, direct grant handover, and a bounded-hold preemption limit. Address and data widths and both slave windows are parameters, and an unmapped access raises a decode-error flag. The block sits between the CPU/DMA masters and the memory/peripheral slaves.

Parameters:
ADDR_W, 16, address width
DATA_W, 64, data width
S0_BASE, 16'h0000, slave 0 window base
S0_SIZE, 16'h0800, slave 0 window size (words)
S1_BASE, 16'h7000, slave 1 window base
S1_SIZE, 16'h0200, slave 1 window size
MAX_HOLD, 8, maximum consecutive granted cycles while the other master waits (0 = unlimited)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active-low
m0_req, m1_req  in  1  master bus request
m0_wr, m1_wr  in  1  master write enable
m0_addr, m1_addr  in  ADDR_W  master address
m0_dout, m1_dout  in  DATA_W  master write data
m0_grant, m1_grant  out  1  bus grant (registered; at most one high)
m_din  out  DATA_W  read data, broadcast to both masters
s_wr  out  1  slave write enable
s_addr  out  ADDR_W  slave address
s_din  out  DATA_W  slave write data
s0_sel, s1_sel  out  1  slave selects
s0_dout, s1_dout  in  DATA_W  slave read data
dec_err  out  1  granted access hits no window

Behaviour:
- Reset: reset_n low forces the following immediately, independent of clk: state=IDLE, last=M1 (M0 wins the first tie), hold_cnt=0, rd_sel=2'b00. All outputs read 0: grants, sels, s_wr, s_addr, s_din, m_din, dec_err.
- A reset mid-transfer drops the grant at once. No partial state survives.
- FSM states are IDLE, G0 and G1. Grants decode from state only: G0 gives m0_grant=1, G1 gives m1_grant=1.
- Transitions in IDLE:
  - Only m0_req high: go to G0.
  - Only m1_req high: go to G1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- Request-to-grant latency is 1 clock.
- Transitions in Gx:
  - mx_req low, other master requesting: go directly to G(other) with no IDLE bubble.
  - mx_req low, other master not requesting: go to IDLE.
  - mx_req high, other master requesting, MAX_HOLD≠0, and hold_cnt==MAX_HOLD-1: preempt to G(other).
  - Otherwise stay in Gx.
- last is updated to x on every entry into Gx.
- hold_cnt clears on every entry into a grant state and increments each cycle the grant is held. It saturates at MAX_HOLD-1.
- Bus mux is combinational from state:
  - In Gx: s_wr, s_addr and s_din follow master x.
  - In IDLE: all three drive 0 (never X).
- Decode is combinational, active only in G0 or G1:
  - s0_sel when S0_BASE ≤ s_addr < S0_BASE+S0_SIZE.
  - s1_sel when S1_BASE ≤ s_addr < S1_BASE+S1_SIZE.
  - S0 has priority on window overlap.
  - A granted access hitting neither window sets dec_err=1 with no sel asserted.
- Window-end compare uses ADDR_W+1 bits so a window ending at 2^ADDR_W does not wrap.
- Read path: rd_sel <= {s0_sel,s1_sel} each clock.
  - rd_sel=10 gives m_din=s0_dout.
  - rd_sel=01 gives m_din=s1_dout.
  - Any other value gives m_din=0.
  - Read data is therefore valid one cycle after the address phase.
- Simultaneous deassert by the holder and assert by the other master yields a same-edge handover. The old master's read data still returns in the following cycle via rd_sel.

Test Plan:
- Reset: assert reset_n=0 mid-cycle during G0 -> grants, sels, s_wr and dec_err all go 0 immediately; after release, m_din=0.
- Single master: m1_req=1, m1_addr=16'h7010, m1_wr=0, s1_dout=64'hA5 -> m1_grant=1 one clock later; s1_sel=1; m_din=64'hA5 on the next cycle.
- Tie after reset: m0_req=m1_req=1 on the same edge -> G0 first. Then drop m0_req -> G1 on the next edge with no IDLE cycle.
- Preemption: m0_req held high with m1_req high, MAX_HOLD=8 -> m0_grant high for exactly 8 cycles, then m1_grant. Repeat with MAX_HOLD=0 -> m0 keeps the bus indefinitely.
- Decode boundaries: addr 16'h07FF -> s0_sel; 16'h0800 -> dec_err=1 and m_din=0 next cycle; 16'h71FF -> s1_sel; 16'h7200 -> dec_err.
- Write path: m0_wr=1, m0_addr=16'h0004, m0_dout=64'h1122334455667788 while granted -> s_wr=1, s_addr=16'h0004, s_din=64'h1122334455667788, s0_sel=1 in the same cycle.

Source files
------------

// File: rtl/bus_arb2m.sv
// Two-master, two-slave shared bus: round-robin arbitration with direct handover,
// bounded-hold preemption, address-window decode and a registered read-return select.
module bus_arb2m #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DATA_W   = 64,
    parameter logic [ADDR_W-1:0]    S0_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0]    S0_SIZE  = 16'h0800,
    parameter logic [ADDR_W-1:0]    S1_BASE  = 16'h7000,
    parameter logic [ADDR_W-1:0]    S1_SIZE  = 16'h0200,
    parameter int unsigned          MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,

    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,

    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    output logic              s0_sel,
    output logic              s1_sel,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic              dec_err
);

    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldMax = (MAX_HOLD > 0) ? HoldW'(MAX_HOLD - 1) : '0;

    // Window bounds carry one extra bit so a window ending at 2^ADDR_W does not wrap.
    localparam logic [ADDR_W:0] S0Lo = {1'b0, S0_BASE};
    localparam logic [ADDR_W:0] S0Hi = {1'b0, S0_BASE} + {1'b0, S0_SIZE};
    localparam logic [ADDR_W:0] S1Lo = {1'b0, S1_BASE};
    localparam logic [ADDR_W:0] S1Hi = {1'b0, S1_BASE} + {1'b0, S1_SIZE};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StG0   = 2'd1,
        StG1   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q;          // 0: M0 was granted last, 1: M1
    logic [HoldW-1:0]   hold_q;
    logic               hold_expired;
    logic [1:0]         rd_sel_q;
    logic [ADDR_W:0]    addr_ext;
    logic               granted;
    logic               hit0;
    logic               hit1;

    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HoldMax);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req && (!m1_req || last_q)) begin
                    state_d = StG0;
                end else if (m1_req) begin
                    state_d = StG1;
                end
            end
            StG0: begin
                if (!m0_req) begin
                    state_d = m1_req ? StG1 : StIdle;
                end else if (m1_req && hold_expired) begin
                    state_d = StG1;
                end
            end
            StG1: begin
                if (!m1_req) begin
                    state_d = m0_req ? StG0 : StIdle;
                end else if (m0_req && hold_expired) begin
                    state_d = StG0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            hold_q   <= '0;
            m0_grant <= 1'b0;
            m1_grant <= 1'b0;
        end else begin
            state_q  <= state_d;
            m0_grant <= (state_d == StG0);
            m1_grant <= (state_d == StG1);
            if ((state_d != state_q) && (state_d != StIdle)) begin
                hold_q <= '0;
                last_q <= (state_d == StG1);
            end else if ((state_q != StIdle) && (MAX_HOLD != 0) && (hold_q != HoldMax)) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        unique case (state_q)
            StG0: begin
                s_wr   = m0_wr;
                s_addr = m0_addr;
                s_din  = m0_dout;
            end
            StG1: begin
                s_wr   = m1_wr;
                s_addr = m1_addr;
                s_din  = m1_dout;
            end
            default: ;
        endcase
    end

    assign granted  = (state_q == StG0) || (state_q == StG1);
    assign addr_ext = {1'b0, s_addr};
    assign hit0     = (addr_ext >= S0Lo) && (addr_ext < S0Hi);
    assign hit1     = (addr_ext >= S1Lo) && (addr_ext < S1Hi);

    // S0 wins when the two windows overlap.
    assign s0_sel  = granted && hit0;
    assign s1_sel  = granted && hit1 && !hit0;
    assign dec_err = granted && !hit0 && !hit1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q <= 2'b00;
        end else begin
            rd_sel_q <= {s0_sel, s1_sel};
        end
    end

    always_comb begin
        m_din = '0;
        unique case (rd_sel_q)
            2'b10:   m_din = s0_dout;
            2'b01:   m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule
